// File: rtl/mac_pkg.sv
// Shared definitions for the dot-product accumulator slice: default widths,
// FSM state encoding and the valid/ready beat helper.
package mac_pkg;

  localparam int PROD_W_DEF = 64;
  localparam int ACC_W_DEF  = 72;
  localparam int LEN_W_DEF  = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } mac_state_e;

  // A transfer happens on a cycle where both sides of a handshake agree.
  localparam logic BEAT_ON  = 1'b1;
  localparam logic BEAT_OFF = 1'b0;

  function automatic logic hs_beat(input logic valid, input logic ready);
    return (valid && ready) ? BEAT_ON : BEAT_OFF;
  endfunction

endpackage

// File: rtl/mac_acc_add.sv
// Combinational accumulator adder: acc + zero-extended prod, with carry-out.
// Build option MAC_ACC_SATURATE_EN: when defined, a carry-out clamps the
// result to all-ones; otherwise the result wraps modulo 2^ACC_W.
module mac_acc_add
  import mac_pkg::*;
#(
  parameter int PROD_W = PROD_W_DEF,
  parameter int ACC_W  = ACC_W_DEF
) (
  input  logic [ACC_W-1:0]  acc,
  input  logic [PROD_W-1:0] prod,
  output logic [ACC_W-1:0]  next_acc,
  output logic              carry
);

  logic [ACC_W:0] sum_ext;

  // One extra bit catches the carry; an all-ones accumulator re-carries on any
  // nonzero product, so saturation persists for the rest of the reduction.
  always_comb begin
    sum_ext = {1'b0, acc} + {{(ACC_W - PROD_W + 1){1'b0}}, prod};
    carry   = sum_ext[ACC_W];
`ifdef MAC_ACC_SATURATE_EN
    next_acc = carry ? {ACC_W{1'b1}} : sum_ext[ACC_W-1:0];
`else
    next_acc = sum_ext[ACC_W-1:0];
`endif
  end

endmodule

// File: rtl/mac_dot_accumulator.sv
// Dot-product reduction stage: sums a programmed number of products taken over
// a valid/ready input and presents the result on a registered valid/ready
// output with a sticky overflow flag.
// Build option MAC_ACC_SATURATE_EN selects saturating instead of wrapping
// accumulation (see mac_acc_add); handshake timing is the same either way.
module mac_dot_accumulator
  import mac_pkg::*;
#(
  parameter int PROD_W = PROD_W_DEF,
  parameter int ACC_W  = ACC_W_DEF,
  parameter int LEN_W  = LEN_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [LEN_W-1:0]  cfg_len,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PROD_W-1:0] in_prod,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_acc,
  output logic [LEN_W-1:0]  out_count,
  output logic              overflow,
  output logic              busy
);

  mac_state_e       state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [LEN_W-1:0] count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic             busy_q, busy_d;

  logic [ACC_W-1:0] add_acc;
  logic             add_carry;
  logic [LEN_W-1:0] count_inc;

  mac_acc_add #(
    .PROD_W (PROD_W),
    .ACC_W  (ACC_W)
  ) u_add (
    .acc      (acc_q),
    .prod     (in_prod),
    .next_acc (add_acc),
    .carry    (add_carry)
  );

  assign count_inc = count_q + 1'b1;

  // Next-state and output-register logic; everything holds unless a case acts.
  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    acc_d       = acc_q;
    count_d     = count_q;
    ovf_d       = ovf_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    busy_d      = busy_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          len_d   = cfg_len;
          acc_d   = '0;
          count_d = '0;
          ovf_d   = 1'b0;
          busy_d  = 1'b1;
          if (cfg_len == '0) begin
            state_d     = DONE;
            out_valid_d = 1'b1;
          end else begin
            state_d    = ACCUM;
            in_ready_d = 1'b1;
          end
        end
      end
      ACCUM: begin
        if (hs_beat(in_valid, in_ready_q)) begin
          acc_d   = add_acc;
          count_d = count_inc;
          ovf_d   = ovf_q | add_carry;
          if (count_inc == len_q) begin
            state_d     = DONE;
            in_ready_d  = 1'b0;
            out_valid_d = 1'b1;
          end
        end
      end
      DONE: begin
        if (hs_beat(out_valid_q, out_ready)) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
          busy_d      = 1'b0;
        end
      end
      default: begin
        state_d     = IDLE;
        in_ready_d  = 1'b0;
        out_valid_d = 1'b0;
        busy_d      = 1'b0;
      end
    endcase
  end

  // State and output registers; reset discards any partial reduction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      len_q       <= '0;
      acc_q       <= '0;
      count_q     <= '0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      acc_q       <= acc_d;
      count_q     <= count_d;
      ovf_q       <= ovf_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_acc   = acc_q;
  assign out_count = count_q;
  assign overflow  = ovf_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_mac_dot_accumulator.sv
// Directed bench for mac_dot_accumulator: a default-width instance and a
// 64-bit accumulator instance share stimulus so overflow is reachable.
module tb_mac_dot_accumulator;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [7:0]  cfg_len;
  logic        in_valid;
  logic [63:0] in_prod;
  logic        out_ready;

  logic        in_ready, out_valid, overflow, busy;
  logic [71:0] out_acc;
  logic [7:0]  out_count;

  logic        in_ready_n, out_valid_n, overflow_n, busy_n;
  logic [63:0] out_acc_n;
  logic [7:0]  out_count_n;

  int n_cmp = 0;
  int n_err = 0;

  mac_dot_accumulator dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cfg_len(cfg_len),
    .in_valid(in_valid), .in_ready(in_ready), .in_prod(in_prod),
    .out_valid(out_valid), .out_ready(out_ready), .out_acc(out_acc),
    .out_count(out_count), .overflow(overflow), .busy(busy)
  );

  mac_dot_accumulator #(.ACC_W(64)) dut_n (
    .clk(clk), .rst_n(rst_n), .start(start), .cfg_len(cfg_len),
    .in_valid(in_valid), .in_ready(in_ready_n), .in_prod(in_prod),
    .out_valid(out_valid_n), .out_ready(out_ready), .out_acc(out_acc_n),
    .out_count(out_count_n), .overflow(overflow_n), .busy(busy_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [63:0] seq_prod [5];
  logic        seq_vld  [5];

  initial begin
    rst_n = 1'b0; start = 1'b0; cfg_len = '0; in_valid = 1'b0;
    in_prod = '0; out_ready = 1'b0;
    step(); step();
    rst_n = 1'b1;
    step();

    // reset state
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_acc", out_acc, 0);
    chk("rst_count", out_count, 0);
    chk("rst_ovf", overflow, 0);

    // 1: basic 2-beat sum
    start = 1'b1; cfg_len = 8'd2;
    step();
    start = 1'b0;
    chk("t1_in_ready", in_ready, 1);
    chk("t1_busy", busy, 1);
    chk("t1_valid_early", out_valid, 0);
    in_valid = 1'b1; in_prod = 64'd1082152022374638;
    step();
    chk("t1_count_mid", out_count, 1);
    chk("t1_valid_mid", out_valid, 0);
    in_prod = 64'd246913575308642;
    step();
    in_valid = 1'b0;
    chk("t1_out_valid", out_valid, 1);
    chk("t1_in_ready_drop", in_ready, 0);
    chk("t1_acc", out_acc, 128'd1329065597683280);
    chk("t1_count", out_count, 2);
    chk("t1_ovf", overflow, 0);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("t1_idle_valid", out_valid, 0);
    chk("t1_idle_busy", busy, 0);
    chk("t1_idle_acc_held", out_acc, 128'd1329065597683280);

    // 2: backpressure on both sides
    seq_vld[0] = 1; seq_vld[1] = 0; seq_vld[2] = 1; seq_vld[3] = 0; seq_vld[4] = 1;
    seq_prod[0] = 1; seq_prod[1] = 64'hDEAD; seq_prod[2] = 2; seq_prod[3] = 64'hBEEF; seq_prod[4] = 3;
    start = 1'b1; cfg_len = 8'd3;
    step();
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_valid = seq_vld[i]; in_prod = seq_prod[i];
      step();
    end
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t2_hold_valid%0d", i), out_valid, 1);
      chk($sformatf("t2_hold_acc%0d", i), out_acc, 6);
      step();
    end
    chk("t2_count", out_count, 3);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("t2_idle_valid", out_valid, 0);
    chk("t2_idle_in_ready", in_ready, 0);

    // 3: zero length; an offered beat must not be taken
    start = 1'b1; cfg_len = 8'd0; in_valid = 1'b1; in_prod = 64'd99;
    step();
    start = 1'b0;
    chk("t3_out_valid", out_valid, 1);
    chk("t3_acc", out_acc, 0);
    chk("t3_count", out_count, 0);
    chk("t3_in_ready", in_ready, 0);
    step();
    in_valid = 1'b0;
    chk("t3_acc_still0", out_acc, 0);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;

    // 4: overflow in the 64-bit instance, none in the 72-bit one
    start = 1'b1; cfg_len = 8'd2;
    step();
    start = 1'b0;
    in_valid = 1'b1; in_prod = 64'hFFFF_FFFF_FFFF_FFFF;
    step();
    in_prod = 64'd2;
    step();
    in_valid = 1'b0;
`ifdef MAC_ACC_SATURATE_EN
    chk("t4_acc64", out_acc_n, 128'hFFFF_FFFF_FFFF_FFFF);
`else
    chk("t4_acc64", out_acc_n, 1);
`endif
    chk("t4_ovf64", overflow_n, 1);
    chk("t4_valid64", out_valid_n, 1);
    chk("t4_acc72", out_acc, 128'h1_0000_0000_0000_0001);
    chk("t4_ovf72", overflow, 0);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("t4_ovf64_sticky_idle", overflow_n, 1);

    // 5: asynchronous reset mid-ACCUM
    start = 1'b1; cfg_len = 8'd4;
    step();
    start = 1'b0;
    in_valid = 1'b1; in_prod = 64'd7;
    step(); step();
    in_valid = 1'b0;
    chk("t5_count_pre", out_count, 2);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_rst_in_ready", in_ready, 0);
    chk("t5_rst_busy", busy, 0);
    chk("t5_rst_acc", out_acc, 0);
    chk("t5_rst_count", out_count, 0);
    chk("t5_rst_ovf64", overflow_n, 0);
    step();
    rst_n = 1'b1;
    step();
    start = 1'b1; cfg_len = 8'd1;
    step();
    start = 1'b0;
    in_valid = 1'b1; in_prod = 64'd5;
    step();
    in_valid = 1'b0;
    chk("t5_valid", out_valid, 1);
    chk("t5_acc", out_acc, 5);
    chk("t5_ovf", overflow, 0);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;

    // 6: start during ACCUM is ignored
    start = 1'b1; cfg_len = 8'd2;
    step();
    cfg_len = 8'd5;
    in_valid = 1'b1; in_prod = 64'd10;
    step();
    start = 1'b0;
    in_prod = 64'd20;
    step();
    in_valid = 1'b0;
    chk("t6_valid", out_valid, 1);
    chk("t6_count", out_count, 2);
    chk("t6_acc", out_acc, 30);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("t6_idle", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mac_dot_accumulator.md
Name: mac_dot_accumulator

Overview:
Downstream stage of karatsuba_mac. Consumes a stream of 64-bit products over a valid/ready handshake and sums a programmed number of them into a wide accumulator (dot-product reduction). Presents the finished sum on a registered valid/ready output port, together with a sticky overflow flag.

Parameters:
PROD_W, 64, product input width; matches the karatsuba_mac result width.
ACC_W, 72, accumulator and result width; must be >= PROD_W.
LEN_W, 8, width of the programmed product count.

Ports:
clk  input  1  single clock, rising-edge.
rst_n  input  1  asynchronous, active-low reset.
start  input  1  pulse that begins a reduction; sampled only in IDLE.
cfg_len  input  LEN_W  number of products to sum; latched on an accepted start.
in_valid  input  1  in_prod is valid.
in_ready  output  1  block accepts in_prod.
in_prod  input  PROD_W  unsigned product from karatsuba_mac.
out_valid  output  1  out_acc holds a finished sum.
out_ready  input  1  consumer accepts out_acc.
out_acc  output  ACC_W  unsigned sum.
out_count  output  LEN_W  products accepted in the current or finished reduction.
overflow  output  1  sticky; set when a carry leaves ACC_W during the reduction.
busy  output  1  high in ACCUM or DONE.

Behaviour:
- Reset (asynchronous assert, synchronous release): state=IDLE, in_ready=0, out_valid=0, out_acc=0, out_count=0, overflow=0, busy=0, latched length=0.
- FSM states: IDLE, ACCUM, DONE.
- IDLE:
  - in_ready=0.
  - start=1 latches cfg_len and clears acc, out_count and overflow.
  - If cfg_len!=0, go to ACCUM. If cfg_len==0, go directly to DONE with out_acc=0.
- ACCUM:
  - in_ready=1 (registered, not dependent on in_valid).
  - Each beat with in_valid&&in_ready adds zero-extended in_prod to acc and increments out_count.
  - The beat that makes out_count equal the latched length moves to DONE. out_valid rises the cycle after that beat (1-cycle latency), and in_ready drops in the same cycle.
  - in_valid=0 cycles: hold all state.
- DONE:
  - out_valid=1; out_acc, out_count and overflow are held stable.
  - out_valid&&out_ready moves to IDLE next cycle with out_valid=0.
  - out_acc and out_count keep their values in IDLE until the next accepted start.
- start is ignored in ACCUM and DONE.
- cfg_len changes after start are ignored.
- Arithmetic: unsigned; sum = acc + {0,in_prod} modulo 2^ACC_W. A carry out of bit ACC_W-1 sets overflow, which stays set until the next start or reset.
- Reset mid-ACCUM or mid-DONE: immediately returns to reset values. Partial sums are discarded.
- Back-to-back: the earliest next start is the cycle after the out handshake, because IDLE must be entered first.
- Default sizing (ACC_W=72, LEN_W=8) cannot overflow. Overflow is reachable only when ACC_W is reduced.

Optional Feature:
- Macro MAC_ACC_SATURATE_EN.
- Defined: on carry out, acc clamps to all-ones and stays there for the remainder of the reduction; overflow is set.
- Undefined: acc wraps modulo 2^ACC_W; overflow is still set.
- Handshake timing is identical in both builds.

Decomposition:
- Package mac_pkg:
  - PROD_W and ACC_W defaults.
  - State enum {IDLE, ACCUM, DONE}.
  - Handshake beat helper constants.
- Sub-module mac_acc_add: combinational ACC_W adder taking acc and in_prod, returning next_acc and carry. Saturation is applied under MAC_ACC_SATURATE_EN.
- The FSM, counter and output registers live in mac_dot_accumulator.

Test Plan:
1. Basic 2-beat sum.
   - Stimulus: start, cfg_len=2; beats 1082152022374638 (12345678*87654321) and 246913575308642 (11111111*22222222) on consecutive cycles; out_ready=1.
   - Response: out_valid one cycle after the 2nd beat; out_acc=1329065597683280; out_count=2; overflow=0.
2. Backpressure on both sides.
   - Stimulus: cfg_len=3; in_valid toggles 1,0,1,0,1 with products 1,2,3; out_ready held 0 for 4 cycles.
   - Response: out_acc=6 held stable with out_valid=1 until out_ready; then IDLE with in_ready=0.
3. Zero length.
   - Stimulus: start with cfg_len=0.
   - Response: out_valid next cycle; out_acc=0; out_count=0; no beats accepted (in_ready stays 0).
4. Overflow (ACC_W=64).
   - Stimulus: cfg_len=2; beats 0xFFFFFFFFFFFFFFFF and 2.
   - Response without macro: out_acc=1, overflow=1.
   - Response with MAC_ACC_SATURATE_EN: out_acc=0xFFFFFFFFFFFFFFFF, overflow=1.
5. Reset mid-operation.
   - Stimulus: cfg_len=4; accept 2 beats; assert rst_n=0 asynchronously between edges.
   - Response: outputs go to reset values immediately. A new start with cfg_len=1 and beat 5 gives out_acc=5, overflow=0.
6. Ignored start.
   - Stimulus: start pulse during ACCUM with a different cfg_len.
   - Response: the original length is kept; out_count equals the originally latched cfg_len.
